// File: rtl/duel_pkg.sv
// Shared definitions for the duel game engine: game states, keypad codes
// and the rectangle overlap test used by the collision logic.
package duel_pkg;

  typedef enum logic [1:0] {
    GS_IDLE  = 2'd0,
    GS_PLAY  = 2'd1,
    GS_PAUSE = 2'd2,
    GS_OVER  = 2'd3
  } game_state_t;

  // Plain 2-bit encodings of the states for the state register.
  localparam logic [1:0] ST_IDLE  = GS_IDLE;
  localparam logic [1:0] ST_PLAY  = GS_PLAY;
  localparam logic [1:0] ST_PAUSE = GS_PAUSE;
  localparam logic [1:0] ST_OVER  = GS_OVER;

  localparam logic [3:0] KEY_P1_UP   = 4'h5;
  localparam logic [3:0] KEY_P1_DN   = 4'h0;
  localparam logic [3:0] KEY_P2_UP   = 4'h3;
  localparam logic [3:0] KEY_P2_DN   = 4'h9;
  localparam logic [3:0] KEY_P1_FIRE = 4'hA;
  localparam logic [3:0] KEY_P2_FIRE = 4'hB;
  localparam logic [3:0] KEY_START   = 4'hC;
  localparam logic [3:0] KEY_PAUSE   = 4'hD;

  // Strict AABB overlap: touching edges do not count as a hit.
  // Operands are widened to 16 bits so coordinate plus size never wraps.
  function automatic logic rect_overlap(
    input logic [15:0] ax, input logic [15:0] ay,
    input logic [15:0] aw, input logic [15:0] ah,
    input logic [15:0] bx, input logic [15:0] by,
    input logic [15:0] bw, input logic [15:0] bh
  );
    return (ax < (bx + bw)) && (bx < (ax + aw)) &&
           (ay < (by + bh)) && (by < (ay + ah));
  endfunction

endpackage

// File: rtl/duel_game_engine_bullet_bank.sv
// One player's bullet slots: lowest-free-slot spawn, per-tick motion,
// screen-edge removal and removal requested by the collision logic.
module bullet_bank
  import duel_pkg::*;
#(
  parameter int COORD_W     = 11,
  parameter int MAX_BULLETS = 2,
  parameter int SCREEN_W    = 640,
  parameter int BULLET_W    = 10,
  parameter int BULLET_STEP = 4,
  parameter int DIR         = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           tick_en,
  input  logic                           fire,
  input  logic [COORD_W-1:0]             spawn_x,
  input  logic [COORD_W-1:0]             spawn_y,
  input  logic [MAX_BULLETS-1:0]         kill,
  output logic [MAX_BULLETS*COORD_W-1:0] bx,
  output logic [MAX_BULLETS*COORD_W-1:0] by,
  output logic [MAX_BULLETS-1:0]         active
);

  localparam int CW1 = COORD_W + 1;

  logic [COORD_W-1:0]     x_r [MAX_BULLETS];
  logic [COORD_W-1:0]     y_r [MAX_BULLETS];
  logic [MAX_BULLETS-1:0] active_r;
  logic [MAX_BULLETS-1:0] grant_s;
  logic [MAX_BULLETS-1:0] edge_s;
  logic [COORD_W-1:0]     nxt_x_s [MAX_BULLETS];
  logic                   taken_s;

  // Pick the lowest-index slot that is free at the start of the cycle.
  always_comb begin
    grant_s = '0;
    taken_s = 1'b0;
    for (int i = 0; i < MAX_BULLETS; i++) begin
      if (!active_r[i] && !taken_s) begin
        grant_s[i] = 1'b1;
        taken_s    = 1'b1;
      end else begin
        grant_s[i] = 1'b0;
      end
    end
  end

  // Next x for each slot and whether the move would leave the screen.
  always_comb begin
    edge_s  = '0;
    nxt_x_s = x_r;
    for (int i = 0; i < MAX_BULLETS; i++) begin
      if (DIR > 0) begin
        edge_s[i]  = ({1'b0, x_r[i]} + CW1'(BULLET_W + BULLET_STEP)) > CW1'(SCREEN_W);
        nxt_x_s[i] = x_r[i] + COORD_W'(BULLET_STEP);
      end else begin
        edge_s[i]  = x_r[i] < COORD_W'(BULLET_STEP);
        nxt_x_s[i] = x_r[i] - COORD_W'(BULLET_STEP);
      end
    end
  end

  // Slot state: clear beats spawn, spawn beats the tick result of its slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_r <= '0;
      for (int i = 0; i < MAX_BULLETS; i++) begin
        x_r[i] <= '0;
        y_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MAX_BULLETS; i++) begin
        if (clear) begin
          active_r[i] <= 1'b0;
        end else if (fire && grant_s[i]) begin
          active_r[i] <= 1'b1;
          x_r[i]      <= spawn_x;
          y_r[i]      <= spawn_y;
        end else if (tick_en && active_r[i]) begin
          if (kill[i] || edge_s[i]) begin
            active_r[i] <= 1'b0;
          end else begin
            x_r[i] <= nxt_x_s[i];
          end
        end
      end
    end
  end

  for (genvar g = 0; g < MAX_BULLETS; g++) begin : g_out
    assign bx[g*COORD_W +: COORD_W] = x_r[g];
    assign by[g*COORD_W +: COORD_W] = y_r[g];
  end
  assign active = active_r;

endmodule

// File: rtl/duel_game_engine.sv
// Two-player duel engine: game FSM, paddle positions, collision matrix and
// scoring. Bullet slots live in two bullet_bank instances.
module duel_game_engine
  import duel_pkg::*;
#(
  parameter int COORD_W     = 11,
  parameter int MAX_BULLETS = 2,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int P1_X        = 25,
  parameter int P2_X        = 565,
  parameter int Y_INIT      = 80,
  parameter int PLAYER_W    = 50,
  parameter int PLAYER_H    = 100,
  parameter int BULLET_W    = 10,
  parameter int BULLET_H    = 30,
  parameter int TOP_MARGIN  = 10,
  parameter int PLAYER_STEP = 10,
  parameter int BULLET_STEP = 4,
  parameter int WIN_SCORE   = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             tick,
  input  logic                             key_valid,
  input  logic [3:0]                       key_code,
  output logic [COORD_W-1:0]               p1_y,
  output logic [COORD_W-1:0]               p2_y,
  output logic [MAX_BULLETS*COORD_W-1:0]   b1_x,
  output logic [MAX_BULLETS*COORD_W-1:0]   b1_y,
  output logic [MAX_BULLETS-1:0]           b1_active,
  output logic [MAX_BULLETS*COORD_W-1:0]   b2_x,
  output logic [MAX_BULLETS*COORD_W-1:0]   b2_y,
  output logic [MAX_BULLETS-1:0]           b2_active,
  output logic [$clog2(WIN_SCORE+1)-1:0]   score1,
  output logic [$clog2(WIN_SCORE+1)-1:0]   score2,
  output logic [1:0]                       state,
  output logic [1:0]                       winner
);

  localparam int SCORE_W = $clog2(WIN_SCORE + 1);
  localparam int CW1     = COORD_W + 1;
  localparam logic [SCORE_W-1:0] WIN_S = SCORE_W'(WIN_SCORE);

  logic [COORD_W-1:0] p1_y_r, p2_y_r, p1_y_nxt_s, p2_y_nxt_s;
  logic [SCORE_W-1:0] score1_r, score2_r, s1_nxt_s, s2_nxt_s;
  logic [1:0]         state_r, winner_r;
  logic [MAX_BULLETS-1:0] bb_kill1_s, bb_kill2_s, hit_kill1_s, hit_kill2_s;
  logic               play_s, tick_en_s, start_s, pause_key_s, win_s, clear_s;
  logic               hit1_s, hit2_s, pair_s;

  // Clamped paddle move: step if it fits, otherwise snap to the limit.
  function automatic logic [COORD_W-1:0] move_y(input logic [COORD_W-1:0] y,
                                                input logic up, input logic dn);
    if (up) begin
      if ({1'b0, y} >= CW1'(TOP_MARGIN + PLAYER_STEP)) return y - COORD_W'(PLAYER_STEP);
      else return COORD_W'(TOP_MARGIN);
    end else if (dn) begin
      if (({1'b0, y} + CW1'(PLAYER_H + PLAYER_STEP)) <= CW1'(SCREEN_H)) return y + COORD_W'(PLAYER_STEP);
      else return COORD_W'(SCREEN_H - PLAYER_H);
    end else begin
      return y;
    end
  endfunction

  assign play_s      = (state_r == ST_PLAY);
  assign tick_en_s   = tick && play_s;
  assign start_s     = key_valid && (key_code == KEY_START) &&
                       ((state_r == ST_IDLE) || (state_r == ST_OVER));
  assign pause_key_s = key_valid && (key_code == KEY_PAUSE);
  assign clear_s     = start_s || win_s;

  // Paddle moves, collision matrix, hits and post-tick scores.
  always_comb begin
    p1_y_nxt_s  = move_y(p1_y_r, key_valid && (key_code == KEY_P1_UP), key_valid && (key_code == KEY_P1_DN));
    p2_y_nxt_s  = move_y(p2_y_r, key_valid && (key_code == KEY_P2_UP), key_valid && (key_code == KEY_P2_DN));
    bb_kill1_s  = '0;
    bb_kill2_s  = '0;
    hit_kill1_s = '0;
    hit_kill2_s = '0;
    pair_s      = 1'b0;
    for (int i = 0; i < MAX_BULLETS; i++) begin
      for (int j = 0; j < MAX_BULLETS; j++) begin
        pair_s = b1_active[i] && b2_active[j] &&
                 rect_overlap(16'(b1_x[i*COORD_W +: COORD_W]), 16'(b1_y[i*COORD_W +: COORD_W]),
                              16'(BULLET_W), 16'(BULLET_H),
                              16'(b2_x[j*COORD_W +: COORD_W]), 16'(b2_y[j*COORD_W +: COORD_W]),
                              16'(BULLET_W), 16'(BULLET_H));
        bb_kill1_s[i] = bb_kill1_s[i] | pair_s;
        bb_kill2_s[j] = bb_kill2_s[j] | pair_s;
      end
    end
    for (int i = 0; i < MAX_BULLETS; i++) begin
      hit_kill1_s[i] = b1_active[i] && !bb_kill1_s[i] &&
                       rect_overlap(16'(b1_x[i*COORD_W +: COORD_W]), 16'(b1_y[i*COORD_W +: COORD_W]),
                                    16'(BULLET_W), 16'(BULLET_H),
                                    16'(P2_X), 16'(p2_y_r), 16'(PLAYER_W), 16'(PLAYER_H));
      hit_kill2_s[i] = b2_active[i] && !bb_kill2_s[i] &&
                       rect_overlap(16'(b2_x[i*COORD_W +: COORD_W]), 16'(b2_y[i*COORD_W +: COORD_W]),
                                    16'(BULLET_W), 16'(BULLET_H),
                                    16'(P1_X), 16'(p1_y_r), 16'(PLAYER_W), 16'(PLAYER_H));
    end
    hit1_s = |hit_kill1_s;
    hit2_s = |hit_kill2_s;
    if (hit1_s && (score1_r != WIN_S)) s1_nxt_s = score1_r + SCORE_W'(1);
    else s1_nxt_s = score1_r;
    if (hit2_s && (score2_r != WIN_S)) s2_nxt_s = score2_r + SCORE_W'(1);
    else s2_nxt_s = score2_r;
    win_s = tick_en_s && ((s1_nxt_s == WIN_S) || (s2_nxt_s == WIN_S));
  end

  // Game FSM, paddles, scores and winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_y_r   <= COORD_W'(Y_INIT);
      p2_y_r   <= COORD_W'(Y_INIT);
      score1_r <= '0;
      score2_r <= '0;
      state_r  <= ST_IDLE;
      winner_r <= 2'd0;
    end else if (start_s) begin
      p1_y_r   <= COORD_W'(Y_INIT);
      p2_y_r   <= COORD_W'(Y_INIT);
      score1_r <= '0;
      score2_r <= '0;
      state_r  <= ST_PLAY;
      winner_r <= 2'd0;
    end else if (play_s) begin
      p1_y_r <= p1_y_nxt_s;
      p2_y_r <= p2_y_nxt_s;
      if (tick_en_s) begin
        score1_r <= s1_nxt_s;
        score2_r <= s2_nxt_s;
      end
      if (win_s) begin
        state_r <= ST_OVER;
        if ((s1_nxt_s == WIN_S) && (s2_nxt_s == WIN_S)) winner_r <= 2'd3;
        else if (s1_nxt_s == WIN_S) winner_r <= 2'd1;
        else winner_r <= 2'd2;
      end else if (pause_key_s) begin
        state_r <= ST_PAUSE;
      end
    end else if ((state_r == ST_PAUSE) && pause_key_s) begin
      state_r <= ST_PLAY;
    end
  end

  bullet_bank #(
    .COORD_W(COORD_W), .MAX_BULLETS(MAX_BULLETS), .SCREEN_W(SCREEN_W),
    .BULLET_W(BULLET_W), .BULLET_STEP(BULLET_STEP), .DIR(1)
  ) u_bank1 (
    .clk(clk), .rst(rst), .clear(clear_s), .tick_en(tick_en_s),
    .fire(play_s && key_valid && (key_code == KEY_P1_FIRE)),
    .spawn_x(COORD_W'(P1_X + PLAYER_W)), .spawn_y(p1_y_r + COORD_W'(PLAYER_H / 2)),
    .kill(bb_kill1_s | hit_kill1_s), .bx(b1_x), .by(b1_y), .active(b1_active)
  );

  bullet_bank #(
    .COORD_W(COORD_W), .MAX_BULLETS(MAX_BULLETS), .SCREEN_W(SCREEN_W),
    .BULLET_W(BULLET_W), .BULLET_STEP(BULLET_STEP), .DIR(-1)
  ) u_bank2 (
    .clk(clk), .rst(rst), .clear(clear_s), .tick_en(tick_en_s),
    .fire(play_s && key_valid && (key_code == KEY_P2_FIRE)),
    .spawn_x(COORD_W'(P2_X - BULLET_W)), .spawn_y(p2_y_r + COORD_W'(PLAYER_H / 2)),
    .kill(bb_kill2_s | hit_kill2_s), .bx(b2_x), .by(b2_y), .active(b2_active)
  );

  assign p1_y   = p1_y_r;
  assign p2_y   = p2_y_r;
  assign score1 = score1_r;
  assign score2 = score2_r;
  assign state  = state_r;
  assign winner = winner_r;

endmodule

// File: tb/tb_duel_game_engine.sv
// Directed bench for duel_game_engine: expectations go into a scoreboard
// queue when a step is driven and are popped against the outputs after it.
module tb_duel_game_engine;
  import duel_pkg::*;

  localparam int CW = 11;
  localparam int NB = 2;

  logic          clk = 1'b0;
  logic          rst, tick, key_valid;
  logic [3:0]    key_code;
  logic [CW-1:0] p1_y, p2_y;
  logic [NB*CW-1:0] b1_x, b1_y, b2_x, b2_y;
  logic [NB-1:0] b1_active, b2_active;
  logic [2:0]    score1, score2;
  logic [1:0]    state, winner;

  duel_game_engine dut (
    .clk(clk), .rst(rst), .tick(tick), .key_valid(key_valid), .key_code(key_code),
    .p1_y(p1_y), .p2_y(p2_y),
    .b1_x(b1_x), .b1_y(b1_y), .b1_active(b1_active),
    .b2_x(b2_x), .b2_y(b2_y), .b2_active(b2_active),
    .score1(score1), .score2(score2), .state(state), .winner(winner)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    tests_run++;
    if (sb_q.size() == 0) begin
      tests_failed++;
      $error("FAIL sb_empty: observed %0d with no expected entry", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        tests_failed++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic step(input logic t, input logic kv, input logic [3:0] kc);
    tick = t; key_valid = kv; key_code = kc;
    @(posedge clk); #1;
    tick = 1'b0; key_valid = 1'b0; key_code = 4'h0;
  endtask

  task automatic key(input logic [3:0] kc);
    step(1'b0, 1'b1, kc);
  endtask

  task automatic tk();
    step(1'b1, 1'b0, 4'h0);
  endtask

  // Tick until every bullet is gone; an exhausted budget shows as a failure.
  task automatic run_until_clear(input string tag, input int budget);
    int n = 0;
    while (((b1_active | b2_active) != 2'b00) && (n < budget)) begin
      tk();
      n++;
    end
    push(tag, 0);
    pop_check(32'(b1_active | b2_active));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tick = 1'b0; key_valid = 1'b0; key_code = 4'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    push("rst_p1_y", 80); push("rst_p2_y", 80); push("rst_state", 0);
    push("rst_b1_act", 0); push("rst_score1", 0); push("rst_winner", 0);
    pop_check(32'(p1_y)); pop_check(32'(p2_y)); pop_check(32'(state));
    pop_check(32'(b1_active)); pop_check(32'(score1)); pop_check(32'(winner));

    push("idle_move_ignored", 80); key(KEY_P1_DN); pop_check(32'(p1_y));
    push("start_play", 1); key(KEY_START); pop_check(32'(state));

    for (int k = 1; k <= 5; k++) begin
      push("p1_down", 32'(80 + 10 * k)); key(KEY_P1_DN); pop_check(32'(p1_y));
    end
    for (int k = 1; k <= 5; k++) begin
      push("p1_up", 32'(130 - 10 * k)); key(KEY_P1_UP); pop_check(32'(p1_y));
    end

    repeat (7) key(KEY_P1_UP);
    push("p1_top", 10); pop_check(32'(p1_y));
    push("p1_top_clamp", 10); key(KEY_P1_UP); pop_check(32'(p1_y));
    repeat (7) key(KEY_P1_DN);
    push("p1_back", 80); pop_check(32'(p1_y));

    repeat (30) key(KEY_P2_DN);
    push("p2_bottom", 380); pop_check(32'(p2_y));
    push("p2_bottom_clamp", 380); key(KEY_P2_DN); pop_check(32'(p2_y));
    repeat (30) key(KEY_P2_UP);
    push("p2_back", 80); pop_check(32'(p2_y));

    push("fire1_act", 1); key(KEY_P1_FIRE); pop_check(32'(b1_active));
    push("fire1_x", 75); push("fire1_y", 130);
    pop_check(32'(b1_x[10:0])); pop_check(32'(b1_y[10:0]));
    push("fire2_act", 3); key(KEY_P1_FIRE); pop_check(32'(b1_active));
    push("fire2_x", 75); push("fire2_y", 130);
    pop_check(32'(b1_x[21:11])); pop_check(32'(b1_y[21:11]));
    push("fire3_ignored", 3); key(KEY_P1_FIRE); pop_check(32'(b1_active));
    repeat (10) tk();
    push("slot0_x_10_ticks", 115); pop_check(32'(b1_x[10:0]));
    run_until_clear("double_hit_clear", 200);
    push("double_hit_score1", 1); pop_check(32'(score1));

    key(KEY_P1_FIRE);
    push("p2_spawn_x", 555); push("p2_spawn_y", 130); key(KEY_P2_FIRE);
    pop_check(32'(b2_x[10:0])); pop_check(32'(b2_y[10:0]));
    repeat (59) tk();
    push("bb_pre_x1", 311); push("bb_pre_x2", 319); push("bb_pre_act1", 1); push("bb_pre_act2", 1);
    pop_check(32'(b1_x[10:0])); pop_check(32'(b2_x[10:0]));
    pop_check(32'(b1_active)); pop_check(32'(b2_active));
    tk();
    push("bb_act1", 0); push("bb_act2", 0); push("bb_score1", 1); push("bb_score2", 0);
    pop_check(32'(b1_active)); pop_check(32'(b2_active));
    pop_check(32'(score1)); pop_check(32'(score2));

    key(KEY_P1_FIRE);
    repeat (5) tk();
    push("pre_pause_x", 95); pop_check(32'(b1_x[10:0]));
    push("pause_state", 2); key(KEY_PAUSE); pop_check(32'(state));
    repeat (20) tk();
    push("paused_x", 95); push("paused_act", 1);
    pop_check(32'(b1_x[10:0])); pop_check(32'(b1_active));
    push("paused_fire_ignored", 1); key(KEY_P1_FIRE); pop_check(32'(b1_active));
    push("resume_state", 1); key(KEY_PAUSE); pop_check(32'(state));
    push("resumed_x", 99); tk(); pop_check(32'(b1_x[10:0]));
    run_until_clear("pause_bullet_clear", 200);
    push("score1_two", 2); pop_check(32'(score1));

    key(KEY_P1_FIRE);
    run_until_clear("third_hit_clear", 200);
    push("score1_three", 3); pop_check(32'(score1));

    key(KEY_P1_DN);
    key(KEY_P1_FIRE);
    repeat (10) tk();
    push("live_before_rst", 1); pop_check(32'(b1_active));
    #2 rst = 1'b1;
    #1;
    push("arst_p1_y", 80); push("arst_b1_act", 0); push("arst_b1_x", 0);
    push("arst_b1_y", 0); push("arst_score1", 0); push("arst_state", 0); push("arst_winner", 0);
    pop_check(32'(p1_y)); pop_check(32'(b1_active)); pop_check(32'(b1_x));
    pop_check(32'(b1_y)); pop_check(32'(score1)); pop_check(32'(state)); pop_check(32'(winner));
    @(posedge clk); #1 rst = 1'b0;

    push("restart_state", 1); key(KEY_START); pop_check(32'(state));
    for (int k = 1; k <= 4; k++) begin
      key(KEY_P1_FIRE);
      run_until_clear("p1_hit_clear", 200);
      push("p1_score", 32'(k)); pop_check(32'(score1));
    end
    for (int k = 1; k <= 4; k++) begin
      key(KEY_P2_FIRE);
      run_until_clear("p2_hit_clear", 200);
      push("p2_score", 32'(k)); pop_check(32'(score2));
    end
    repeat (3) key(KEY_P2_DN);
    push("p2_offset", 110); pop_check(32'(p2_y));
    key(KEY_P1_FIRE);
    key(KEY_P2_FIRE);
    run_until_clear("draw_clear", 200);
    push("draw_state", 3); push("draw_winner", 3); push("draw_score1", 5); push("draw_score2", 5);
    pop_check(32'(state)); pop_check(32'(winner)); pop_check(32'(score1)); pop_check(32'(score2));
    push("over_move_ignored", 80); key(KEY_P1_DN); pop_check(32'(p1_y));

    key(KEY_START);
    push("newgame_state", 1); push("newgame_winner", 0); push("newgame_score2", 0); push("newgame_p2_y", 80);
    pop_check(32'(state)); pop_check(32'(winner)); pop_check(32'(score2)); pop_check(32'(p2_y));
    for (int k = 1; k <= 5; k++) begin
      key(KEY_P1_FIRE);
      run_until_clear("win_hit_clear", 200);
      push("win_score1", 32'(k)); pop_check(32'(score1));
      push("win_state", (k == 5) ? 3 : 1); pop_check(32'(state));
    end
    push("win_winner", 1); pop_check(32'(winner));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
